nbit_scan_decoder: RTL and testbench

Parametrised one-hot decoder with a registered index and an optional auto-scan mode. It decodes an N-bit index onto 2^N one-hot outputs. The index can be loaded directly or stepped up or down by a programmable prescaler. Typical use: digit/row select for multiplexed displays and keyboard scanning, and one-hot channel selection in datapaths.

---
 rtl/nbit_scan_decoder.sv | 73 +++++++
 tb/tb_nbit_scan_decoder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/nbit_scan_decoder.sv
// rtl/nbit_scan_decoder.sv - registered one-hot index decoder with prescaled up/down auto-scan
module nbit_scan_decoder #(
   parameter int N   = 3,
   parameter int DIV = 4
) (
   input  logic              clock,
   input  logic              reset_,
   input  logic              en,
   input  logic              load,
   input  logic [N-1:0]      x,
   input  logic              mode_scan,
   input  logic              dir,
   output logic [(1<<N)-1:0] z,
   output logic [N-1:0]      idx,
   output logic              wrap
);

   localparam int W  = 1 << N;
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
   localparam logic [N-1:0]  IDX_TOP = {N{1'b1}};

   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  idx_q, idx_d;
   logic [W-1:0]  z_q, z_d;
   logic          wrap_q, wrap_d;

   always_comb begin
      cnt_d  = cnt_q;
      idx_d  = idx_q;
      wrap_d = 1'b0;
      if (load) begin
         idx_d = x;
         cnt_d = '0;
      end else if (mode_scan) begin
         if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            if (dir) begin
               idx_d  = idx_q - 1'b1;
               wrap_d = (idx_q == '0);
            end else begin
               idx_d  = idx_q + 1'b1;
               wrap_d = (idx_q == IDX_TOP);
            end
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else begin
         // static hold restarts the period so a resumed scan waits a full DIV
         cnt_d = '0;
      end
      z_d = en ? (W'(1) << idx_d) : '0;
   end

   always_ff @(posedge clock) begin
      if (!reset_) begin
         cnt_q  <= '0;
         idx_q  <= '0;
         z_q    <= '0;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         idx_q  <= idx_d;
         z_q    <= z_d;
         wrap_q <= wrap_d;
      end
   end

   assign z    = z_q;
   assign idx  = idx_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_nbit_scan_decoder.sv
// tb/tb_nbit_scan_decoder.sv - directed self-checking bench for nbit_scan_decoder
module tb_nbit_scan_decoder;

   localparam int N = 3;
   localparam int W = 8;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic          reset_, en, load, mode_scan, dir;
   logic [N-1:0]  x;
   logic [W-1:0]  z0, z1;
   logic [N-1:0]  idx0, idx1;
   logic          wrap0, wrap1;

   int checks   = 0;
   int failures = 0;

   nbit_scan_decoder #(.N(N), .DIV(4)) dut0 (
      .clock(clock), .reset_(reset_), .en(en), .load(load), .x(x),
      .mode_scan(mode_scan), .dir(dir), .z(z0), .idx(idx0), .wrap(wrap0)
   );

   nbit_scan_decoder #(.N(N), .DIV(1)) dut1 (
      .clock(clock), .reset_(reset_), .en(en), .load(load), .x(x),
      .mode_scan(mode_scan), .dir(dir), .z(z1), .idx(idx1), .wrap(wrap1)
   );

   typedef struct {
      logic       ld;
      logic [2:0] xv;
      logic       ms;
      logic       dr;
      logic       e;
      logic [2:0] ei;
      logic [7:0] ez;
      logic       ew;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic edge_();
      @(posedge clock);
      #1;
   endtask

   task automatic chk0(input string tag, input logic [2:0] ei, input logic [7:0] ez, input logic ew);
      chk({tag, ".idx"}, 32'(idx0), 32'(ei));
      chk({tag, ".z"}, 32'(z0), 32'(ez));
      chk({tag, ".wrap"}, 32'(wrap0), 32'(ew));
   endtask

   task automatic chk1(input string tag, input logic [2:0] ei, input logic [7:0] ez, input logic ew);
      chk({tag, ".idx"}, 32'(idx1), 32'(ei));
      chk({tag, ".z"}, 32'(z1), 32'(ez));
      chk({tag, ".wrap"}, 32'(wrap1), 32'(ew));
   endtask

   task automatic drive(input logic ld, input logic [2:0] xv, input logic ms, input logic dr, input logic e);
      load = ld; x = xv; mode_scan = ms; dir = dr; en = e;
   endtask

   initial begin
      // ld  x    ms   dr   en  | idx   z           wrap
      tbl.push_back('{1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h01, 1'b0});
      tbl.push_back('{1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 3'd1, 8'h02, 1'b0});
      tbl.push_back('{1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 3'd2, 8'h04, 1'b0});
      tbl.push_back('{1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0});
      tbl.push_back('{1'b1, 3'd4, 1'b0, 1'b0, 1'b1, 3'd4, 8'h10, 1'b0});
      tbl.push_back('{1'b1, 3'd5, 1'b0, 1'b0, 1'b1, 3'd5, 8'h20, 1'b0});
      tbl.push_back('{1'b1, 3'd6, 1'b0, 1'b0, 1'b1, 3'd6, 8'h40, 1'b0});
      tbl.push_back('{1'b1, 3'd7, 1'b0, 1'b0, 1'b1, 3'd7, 8'h80, 1'b0});
      tbl.push_back('{1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 3'd3, 8'h00, 1'b0});
      tbl.push_back('{1'b0, 3'd5, 1'b0, 1'b1, 1'b1, 3'd3, 8'h08, 1'b0});
      // up scan from 6: step every 4 edges, wrap on 7->0
      tbl.push_back('{1'b1, 3'd6, 1'b0, 1'b0, 1'b1, 3'd6, 8'h40, 1'b0});
      tbl.push_back('{1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 3'd6, 8'h40, 1'b0});
      tbl.push_back('{1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 3'd6, 8'h40, 1'b0});
      tbl.push_back('{1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 3'd6, 8'h40, 1'b0});
      tbl.push_back('{1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 3'd7, 8'h80, 1'b0});
      tbl.push_back('{1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 3'd7, 8'h80, 1'b0});
      tbl.push_back('{1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 3'd7, 8'h80, 1'b0});
      tbl.push_back('{1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 3'd7, 8'h80, 1'b0});
      tbl.push_back('{1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 3'd0, 8'h01, 1'b1});
      tbl.push_back('{1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 3'd0, 8'h01, 1'b0});
      // scan pause clears the prescaler: two counts, hold, then a full period again
      tbl.push_back('{1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 3'd0, 8'h01, 1'b0});
      tbl.push_back('{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h01, 1'b0});
      tbl.push_back('{1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 3'd0, 8'h01, 1'b0});
      tbl.push_back('{1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 3'd0, 8'h01, 1'b0});
      tbl.push_back('{1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 3'd0, 8'h01, 1'b0});
      tbl.push_back('{1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 3'd1, 8'h02, 1'b0});

      drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      reset_ = 1'b0;
      edge_();
      edge_();
      chk0("rst0", 3'd0, 8'h00, 1'b0);
      chk1("rst1", 3'd0, 8'h00, 1'b0);
      reset_ = 1'b1;
      edge_();
      chk0("post_rst", 3'd0, 8'h00, 1'b0);
      en = 1'b1;
      edge_();
      chk0("en_on", 3'd0, 8'h01, 1'b0);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].ld, tbl[i].xv, tbl[i].ms, tbl[i].dr, tbl[i].e);
         edge_();
         chk0($sformatf("vec%0d", i), tbl[i].ei, tbl[i].ez, tbl[i].ew);
         if (tbl[i].e) chk($sformatf("vec%0d.onehot", i), 32'($onehot(z0)), 32'd1);
      end

      // DIV=1 down scan: 1,0,7,6 with wrap only on 0->7
      drive(1'b1, 3'd1, 1'b0, 1'b1, 1'b1);
      edge_();
      chk1("d1_load", 3'd1, 8'h02, 1'b0);
      drive(1'b0, 3'd0, 1'b1, 1'b1, 1'b1);
      edge_();
      chk1("d1_s0", 3'd0, 8'h01, 1'b0);
      edge_();
      chk1("d1_s7", 3'd7, 8'h80, 1'b1);
      edge_();
      chk1("d1_s6", 3'd6, 8'h40, 1'b0);

      // load wins over a due tick, even when that tick would wrap
      drive(1'b1, 3'd7, 1'b0, 1'b0, 1'b1);
      edge_();
      drive(1'b0, 3'd0, 1'b1, 1'b0, 1'b1);
      edge_(); edge_(); edge_();
      chk0("pre_tick", 3'd7, 8'h80, 1'b0);
      drive(1'b1, 3'd5, 1'b1, 1'b0, 1'b1);
      edge_();
      chk0("load_at_tick", 3'd5, 8'h20, 1'b0);
      drive(1'b0, 3'd0, 1'b1, 1'b0, 1'b1);
      edge_(); edge_(); edge_();
      chk0("after_load_hold", 3'd5, 8'h20, 1'b0);
      edge_();
      chk0("after_load_step", 3'd6, 8'h40, 1'b0);

      // en=0 blanks z while the index keeps stepping
      en = 1'b0;
      edge_(); edge_(); edge_();
      chk0("blank_hold", 3'd6, 8'h00, 1'b0);
      edge_();
      chk0("blank_step", 3'd7, 8'h00, 1'b0);
      en = 1'b1;
      edge_();
      chk0("unblank", 3'd7, 8'h80, 1'b0);
      edge_();
      dir = 1'b1;
      edge_();
      chk0("dir_flip_hold", 3'd7, 8'h80, 1'b0);
      edge_();
      chk0("dir_flip_step", 3'd6, 8'h40, 1'b0);

      // reset mid-scan at idx=4, cnt=2
      drive(1'b1, 3'd4, 1'b0, 1'b0, 1'b1);
      edge_();
      drive(1'b0, 3'bxxx, 1'b1, 1'b0, 1'b1);
      edge_(); edge_();
      chk0("pre_rst", 3'd4, 8'h10, 1'b0);
      reset_ = 1'b0;
      edge_();
      chk0("mid_rst", 3'd0, 8'h00, 1'b0);
      reset_ = 1'b1;
      edge_(); edge_(); edge_();
      chk0("rst_resume_hold", 3'd0, 8'h01, 1'b0);
      edge_();
      chk0("rst_resume_step", 3'd1, 8'h02, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
